// File: rtl/yin_tau_search_if.sv
// Stream/control bundle for yin_tau_search: start/average, d' sample stream with
// ready/valid, and the published result.
interface yin_tau_search_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAU_BITS   = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] average;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic [TAU_BITS-1:0]   min_tau;
  logic [DATA_WIDTH-1:0] min_value;

  modport master (
    output start, average, in_valid, in_data,
    input  in_ready, busy, done, found, min_tau, min_value
  );

  modport slave (
    input  start, average, in_valid, in_data,
    output in_ready, busy, done, found, min_tau, min_value
  );
endinterface

// File: rtl/yin_tau_search.sv
// Streaming YIN absolute-threshold tau search over one window of d'(tau) samples.
// Optional macro YIN_GLOBAL_MIN_FALLBACK_EN: report the global minimum when nothing crosses.
//
// state   | meaning
// IDLE    | waiting for start; average latched on start
// THRESH  | one cycle: thr = (average*THRESH_NUM) >> THRESH_SHIFT
// SCAN    | looking for the first sample below thr (tau >= MIN_TAU)
// DESCEND | following the dip down to its local minimum
// DRAIN   | result published, consuming the rest of the window
module yin_tau_search #(
  parameter int DATA_WIDTH      = 64,
  parameter int TAU_BITS        = 8,
  parameter int MAX_TAU         = 40,
  parameter int MIN_TAU         = 2,
  parameter int THRESH_NUM_BITS = 16,
  parameter int THRESH_NUM      = 655,
  parameter int THRESH_SHIFT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  yin_tau_search_if.slave   bus
);

  localparam int THR_W = DATA_WIDTH + THRESH_NUM_BITS;
  localparam logic [THRESH_NUM_BITS-1:0] THR_NUM_L = THRESH_NUM_BITS'(THRESH_NUM);
  localparam logic [TAU_BITS-1:0]        LAST_TAU  = TAU_BITS'(MAX_TAU - 1);
  localparam logic [TAU_BITS-1:0]        MIN_TAU_L = TAU_BITS'(MIN_TAU);

  typedef enum logic [2:0] {IDLE, THRESH, SCAN, DESCEND, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] avg_q, avg_d;
  logic [THR_W-1:0]      thr_q, thr_d;
  logic [TAU_BITS-1:0]   tau_q, tau_d;
  logic [TAU_BITS-1:0]   cand_tau_q, cand_tau_d;
  logic [DATA_WIDTH-1:0] cand_val_q, cand_val_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  found_q, found_d;
  logic [TAU_BITS-1:0]   min_tau_q, min_tau_d;
  logic [DATA_WIDTH-1:0] min_value_q, min_value_d;
`ifdef YIN_GLOBAL_MIN_FALLBACK_EN
  logic                  gmin_valid_q, gmin_valid_d;
  logic [TAU_BITS-1:0]   gmin_tau_q, gmin_tau_d;
  logic [DATA_WIDTH-1:0] gmin_val_q, gmin_val_d;
`endif

  logic [THR_W-1:0] thr_calc;
  logic             in_ready_c;
  logic             accept;
  logic             is_last;
  logic             eligible;
  logic             below_thr;

  // Full-width product so the threshold is never truncated before the shift.
  assign thr_calc   = (THR_W'(avg_q) * THR_W'(THR_NUM_L)) >> THRESH_SHIFT;
  assign in_ready_c = (state_q == SCAN) || (state_q == DESCEND) || (state_q == DRAIN);
  assign accept     = bus.in_valid && in_ready_c;
  assign is_last    = (tau_q == LAST_TAU);
  assign eligible   = (tau_q >= MIN_TAU_L);
  assign below_thr  = (THR_W'(bus.in_data) < thr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      avg_q       <= '0;
      thr_q       <= '0;
      tau_q       <= '0;
      cand_tau_q  <= '0;
      cand_val_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      min_tau_q   <= '0;
      min_value_q <= '0;
`ifdef YIN_GLOBAL_MIN_FALLBACK_EN
      gmin_valid_q <= 1'b0;
      gmin_tau_q   <= '0;
      gmin_val_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      avg_q       <= avg_d;
      thr_q       <= thr_d;
      tau_q       <= tau_d;
      cand_tau_q  <= cand_tau_d;
      cand_val_q  <= cand_val_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      min_tau_q   <= min_tau_d;
      min_value_q <= min_value_d;
`ifdef YIN_GLOBAL_MIN_FALLBACK_EN
      gmin_valid_q <= gmin_valid_d;
      gmin_tau_q   <= gmin_tau_d;
      gmin_val_q   <= gmin_val_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    avg_d       = avg_q;
    thr_d       = thr_q;
    tau_d       = tau_q;
    cand_tau_d  = cand_tau_q;
    cand_val_d  = cand_val_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    found_d     = found_q;
    min_tau_d   = min_tau_q;
    min_value_d = min_value_q;
`ifdef YIN_GLOBAL_MIN_FALLBACK_EN
    gmin_valid_d = gmin_valid_q;
    gmin_tau_d   = gmin_tau_q;
    gmin_val_d   = gmin_val_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          avg_d   = bus.average;
          tau_d   = '0;
          busy_d  = 1'b1;
          state_d = THRESH;
`ifdef YIN_GLOBAL_MIN_FALLBACK_EN
          gmin_valid_d = 1'b0;
`endif
        end
      end

      THRESH: begin
        thr_d   = thr_calc;
        state_d = SCAN;
      end

      SCAN: begin
        if (accept) begin
          tau_d = tau_q + 1'b1;
`ifdef YIN_GLOBAL_MIN_FALLBACK_EN
          if (eligible && (!gmin_valid_q || (bus.in_data < gmin_val_q))) begin
            gmin_valid_d = 1'b1;
            gmin_tau_d   = tau_q;
            gmin_val_d   = bus.in_data;
          end
`endif
          if (eligible && below_thr) begin
            cand_tau_d = tau_q;
            cand_val_d = bus.in_data;
            if (is_last) begin
              // Crossing on the final sample is already its own local minimum.
              done_d      = 1'b1;
              found_d     = 1'b1;
              min_tau_d   = tau_q;
              min_value_d = bus.in_data;
              busy_d      = 1'b0;
              state_d     = IDLE;
            end else begin
              state_d = DESCEND;
            end
          end else if (is_last) begin
            done_d  = 1'b1;
            found_d = 1'b0;
`ifdef YIN_GLOBAL_MIN_FALLBACK_EN
            min_tau_d   = gmin_tau_d;
            min_value_d = gmin_val_d;
`else
            min_tau_d   = '0;
            min_value_d = '0;
`endif
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      DESCEND: begin
        if (accept) begin
          tau_d = tau_q + 1'b1;
          if (bus.in_data < cand_val_q) begin
            cand_tau_d = tau_q;
            cand_val_d = bus.in_data;
            if (is_last) begin
              done_d      = 1'b1;
              found_d     = 1'b1;
              min_tau_d   = tau_q;
              min_value_d = bus.in_data;
              busy_d      = 1'b0;
              state_d     = IDLE;
            end
          end else begin
            done_d      = 1'b1;
            found_d     = 1'b1;
            min_tau_d   = cand_tau_q;
            min_value_d = cand_val_q;
            if (is_last) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        if (accept) begin
          tau_d = tau_q + 1'b1;
          if (is_last) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.min_tau   = min_tau_q;
  assign bus.min_value = min_value_q;

endmodule
